// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and EX flush.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [2:0]      id_ex,
  input  logic [1:0]      id_jump_t,
  input  logic            id_slt,
  input  logic            id_lui,
  input  logic            id_reg_we,
  input  logic            id_mem_we,
  input  logic            id_mem_rd,
  input  logic            id_use_rs2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            ex_valid,
  output logic [2:0]      ex_ex,
  output logic [1:0]      ex_jump_t,
  output logic            ex_slt,
  output logic            ex_lui,
  output logic            ex_reg_we,
  output logic            ex_mem_we,
  output logic            ex_mem_rd,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_imm,
`ifdef HAZARD_STATS_EN
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt,
`endif
  output logic            stall_o
);

  typedef struct packed {
    logic            valid;
    logic [2:0]      ex;
    logic [1:0]      jump_t;
    logic            slt;
    logic            lui;
    logic            reg_we;
    logic            mem_we;
    logic            mem_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
  } stage_t;

  stage_t id_s, ex_d, ex_q;
  logic   load_use;

  assign id_s = '{valid: id_valid, ex: id_ex, jump_t: id_jump_t, slt: id_slt, lui: id_lui,
                  reg_we: id_reg_we, mem_we: id_mem_we, mem_rd: id_mem_rd,
                  rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                  pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm};

  // A bubble has valid=0 and mem_rd=0, so it can never raise a follow-on hazard.
  assign load_use = ex_q.valid & ex_q.mem_rd & (ex_q.rd != 5'd0) & id_valid &
                    ((ex_q.rd == id_rs1) | (id_use_rs2 & (ex_q.rd == id_rs2)));
  assign stall_o  = load_use & ~flush_i;

  always_comb begin
    ex_d = id_s;
    if (flush_i)       ex_d = '0;
    else if (hold_i)   ex_d = ex_q;
    else if (load_use) ex_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid  = ex_q.valid;
  assign ex_ex     = ex_q.ex;
  assign ex_jump_t = ex_q.jump_t;
  assign ex_slt    = ex_q.slt;
  assign ex_lui    = ex_q.lui;
  assign ex_reg_we = ex_q.reg_we;
  assign ex_mem_we = ex_q.mem_we;
  assign ex_mem_rd = ex_q.mem_rd;
  assign ex_rs1    = ex_q.rs1;
  assign ex_rs2    = ex_q.rs2;
  assign ex_rd     = ex_q.rd;
  assign ex_pc     = ex_q.pc;
  assign ex_rd1    = ex_q.rd1;
  assign ex_rd2    = ex_q.rd2;
  assign ex_imm    = ex_q.imm;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Stalls that coincide with a hold are not counted; the pipe was frozen anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_o && !hold_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_i && (flush_cnt_q != 16'hFFFF))            flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage; expected stage contents are queued per step
// and popped after the capturing edge. Counter checks are built with HAZARD_STATS_EN.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [2:0]  ex;
    logic [1:0]  jump_t;
    logic        slt;
    logic        lui;
    logic        reg_we;
    logic        mem_we;
    logic        mem_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } stage_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  stage_t id_in = '0;
  logic   use2 = 1'b0, flush = 1'b0, hold = 1'b0;

  logic        ex_valid, ex_slt, ex_lui, ex_reg_we, ex_mem_we, ex_mem_rd, stall_o;
  logic [2:0]  ex_ex;
  logic [1:0]  ex_jump_t;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
  int          m_stall_cnt = 0, m_flush_cnt = 0;
`endif

  int total = 0, bad = 0;
  stage_t m = '0;
  stage_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_in.valid), .id_ex(id_in.ex), .id_jump_t(id_in.jump_t),
    .id_slt(id_in.slt), .id_lui(id_in.lui), .id_reg_we(id_in.reg_we),
    .id_mem_we(id_in.mem_we), .id_mem_rd(id_in.mem_rd), .id_use_rs2(use2),
    .id_rs1(id_in.rs1), .id_rs2(id_in.rs2), .id_rd(id_in.rd),
    .id_pc(id_in.pc), .id_rd1(id_in.rd1), .id_rd2(id_in.rd2), .id_imm(id_in.imm),
    .flush_i(flush), .hold_i(hold),
    .ex_valid(ex_valid), .ex_ex(ex_ex), .ex_jump_t(ex_jump_t), .ex_slt(ex_slt),
    .ex_lui(ex_lui), .ex_reg_we(ex_reg_we), .ex_mem_we(ex_mem_we), .ex_mem_rd(ex_mem_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
`ifdef HAZARD_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .stall_o(stall_o)
  );

  function automatic stage_t dut_ex();
    return {ex_valid, ex_ex, ex_jump_t, ex_slt, ex_lui, ex_reg_we, ex_mem_we, ex_mem_rd,
            ex_rs1, ex_rs2, ex_rd, ex_pc, ex_rd1, ex_rd2, ex_imm};
  endfunction

  function automatic stage_t ins(logic v, logic [2:0] op, logic [1:0] jt, logic we, logic mwe,
                                 logic mrd, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                 logic [31:0] pc);
    stage_t s;
    s = '0;
    s.valid = v; s.ex = op; s.jump_t = jt; s.reg_we = we; s.mem_we = mwe; s.mem_rd = mrd;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.pc = pc;
    s.rd1 = pc ^ 32'hA5A5_0001; s.rd2 = pc ^ 32'h5A5A_0002; s.imm = pc + 32'd12;
    return s;
  endfunction

  function automatic logic hazard(stage_t cur, stage_t id, logic u2);
    return cur.valid && cur.mem_rd && cur.rd != 5'd0 && id.valid &&
           (cur.rd == id.rs1 || (u2 && cur.rd == id.rs2));
  endfunction

  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check the combinational stall, queue the expected next
  // stage contents, then compare them after the edge.
  task automatic step(string tag, stage_t id, logic u2, logic fl, logic hd);
    logic   lu, st;
    stage_t nx;
    stage_t got;
    id_in = id; use2 = u2; flush = fl; hold = hd;
    #1;
    lu = hazard(m, id, u2);
    st = lu && !fl;
    chk({tag, ".stall"}, {159'd0, stall_o}, {159'd0, st});
    if (fl)      nx = '0;
    else if (hd) nx = m;
    else if (lu) nx = '0;
    else         nx = id;
    sb.push_back(nx);
`ifdef HAZARD_STATS_EN
    if (st && !hd && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
    if (fl && m_flush_cnt < 16'hFFFF)        m_flush_cnt++;
`endif
    @(posedge clk);
    #1;
    got = sb.pop_front();
    m = got;
    chk({tag, ".ex"}, {6'd0, dut_ex()}, {6'd0, got});
`ifdef HAZARD_STATS_EN
    chk({tag, ".scnt"}, {144'd0, stall_cnt}, 160'(m_stall_cnt));
    chk({tag, ".fcnt"}, {144'd0, flush_cnt}, 160'(m_flush_cnt));
`endif
  endtask

  task automatic check_reset(string tag);
    m = '0;
`ifdef HAZARD_STATS_EN
    m_stall_cnt = 0; m_flush_cnt = 0;
    chk({tag, ".scnt"}, {144'd0, stall_cnt}, 160'd0);
    chk({tag, ".fcnt"}, {144'd0, flush_cnt}, 160'd0);
`endif
    chk({tag, ".ex"}, {6'd0, dut_ex()}, 160'd0);
    chk({tag, ".stall"}, {159'd0, stall_o}, 160'd0);
  endtask

  stage_t ld, use_i, jal, oth;

  initial begin
    #2 check_reset("rst0");
    #10 rst_n = 1'b1;

    // Reset mid-stream while an ALU op with reg_we, rd=5, pc=0x40 sits in EX.
    step("alu5", ins(1, 3'd0, 2'b00, 1, 0, 0, 5'd1, 5'd2, 5'd5, 32'h40), 1, 0, 0);
    id_in = ins(1, 3'd0, 2'b00, 1, 0, 0, 5'd5, 5'd0, 5'd6, 32'h44);
    rst_n = 1'b0;
    #1 check_reset("rst_mid");
    #1 rst_n = 1'b1;

    // Load x7 then ADD rs1=7: one stall, bubble, then ADD.
    ld    = ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd7, 32'h80);
    use_i = ins(1, 3'd0, 2'b00, 1, 0, 0, 5'd7, 5'd1, 5'd8, 32'h84);
    step("ld7", ld, 0, 0, 0);
    step("use7_stall", use_i, 1, 0, 0);
    step("use7_go", use_i, 1, 0, 0);

    // Load to x0 never stalls.
    step("ld0", ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd0, 32'h90), 0, 0, 0);
    step("use0", ins(1, 3'd0, 2'b00, 1, 0, 0, 5'd0, 5'd0, 5'd9, 32'h94), 1, 0, 0);

    // rs2 match only counts when rs2 is actually read.
    step("ld3", ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd3, 32'hA0), 0, 0, 0);
    step("itype3", ins(1, 3'd1, 2'b00, 1, 0, 0, 5'd4, 5'd3, 5'd10, 32'hA4), 0, 0, 0);
    step("ld3b", ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd3, 32'hA8), 0, 0, 0);
    use_i = ins(1, 3'd2, 2'b00, 0, 1, 0, 5'd4, 5'd3, 5'd0, 32'hAC);
    step("store_rs2_stall", use_i, 1, 0, 0);
    step("store_rs2_go", use_i, 1, 0, 0);

    // Flush coinciding with a load-use: bubble, no stall.
    step("ld9", ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd9, 32'hB0), 0, 0, 0);
    step("flush_lu", ins(1, 3'd0, 2'b00, 1, 0, 0, 5'd9, 5'd0, 5'd11, 32'hB4), 0, 1, 0);

    // Hold 3 cycles with JAL in EX, then release captures the pending instruction.
    jal = ins(1, 3'd0, 2'b01, 1, 0, 0, 5'd0, 5'd0, 5'd1, 32'h100);
    oth = ins(1, 3'd3, 2'b00, 1, 0, 0, 5'd12, 5'd13, 5'd14, 32'h104);
    step("jal", jal, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("hold", oth, 1, 0, 1);
    step("hold_rel", oth, 1, 0, 0);

    // Hold with load-use pending: held, stall asserted but not counted.
    step("ld4", ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd4, 32'h110), 0, 0, 0);
    use_i = ins(1, 3'd0, 2'b00, 1, 0, 0, 5'd4, 5'd0, 5'd15, 32'h114);
    step("hold_lu", use_i, 0, 0, 1);
    step("lu_after_hold", use_i, 0, 0, 0);
    step("lu_go", use_i, 0, 0, 0);

    // Invalid slot: control fields pass through; invalid consumer never stalls.
    step("ld6", ins(1, 3'd0, 2'b00, 1, 0, 1, 5'd2, 5'd0, 5'd6, 32'h120), 0, 0, 0);
    step("inv", ins(0, 3'd5, 2'b11, 1, 1, 1, 5'd6, 5'd6, 5'd6, 32'h124), 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      stage_t r;
      r = ins(1'($urandom_range(0, 5) != 0), 3'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom);
      r.slt = 1'($urandom); r.lui = 1'($urandom);
      step("rnd", r, 1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
